// File: rtl/instructie_sequencer.sv
// Multi-cycle ALU instruction sequencer: register read, ALU execute, register write-back.
// Done pulses 6 cycles after accept (reg-reg), 5 (immediate), 1 (illegal); start is only taken in IDLE/DONE/ERR.
module instructie_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [7:0]            instructie,
   input  logic [15:0]           argument1,
   input  logic [15:0]           argument2,
   output logic                  busy,
   output logic                  done,
   output logic                  illegal,
   output logic [DATA_WIDTH-1:0] outputArgument,
   output logic                  reg_chip_enable,
   output logic                  reg_write_enable,
   output logic [ADDR_WIDTH-1:0] reg_address,
   output logic [DATA_WIDTH-1:0] reg_value_in,
   input  logic [DATA_WIDTH-1:0] reg_value_out,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [5:0]            alu_opcode,
   input  logic [DATA_WIDTH-1:0] alu_result,
   output logic [15:0]           retired
);

   localparam logic [3:0] IDLE  = 4'd0;
   localparam logic [3:0] RD_A  = 4'd1;
   localparam logic [3:0] RD_B  = 4'd2;
   localparam logic [3:0] CAP_B = 4'd3;
   localparam logic [3:0] CAP_A = 4'd4;
   localparam logic [3:0] EXEC  = 4'd5;
   localparam logic [3:0] WB    = 4'd6;
   localparam logic [3:0] DONE  = 4'd7;
   localparam logic [3:0] ERR   = 4'd8;

   logic [3:0]            state, next_state;
   logic [7:0]            instr_q;
   logic [ADDR_WIDTH-1:0] a_q;
   logic [15:0]           b_q;
   logic [DATA_WIDTH-1:0] buf_a, buf_b, res;
   logic                  accept;
   logic                  unused_arg1;

   assign unused_arg1 = ^argument1[15:ADDR_WIDTH];

   // One-hot ALU select; zero means the opcode is not supported.
   function automatic logic [5:0] decode_op(input logic [7:0] ins);
      logic [5:0] oh;
      case (ins[4:0])
         5'd1:    oh = 6'b001000;
         5'd2:    oh = 6'b010000;
         5'd3:    oh = 6'b100000;
         5'd4:    oh = 6'b000010;
         5'd5:    oh = 6'b000100;
         5'd6:    oh = 6'b000001;
         default: oh = 6'b000000;
      endcase
      if (ins[7:6] != 2'b00) oh = 6'b000000;
      return oh;
   endfunction

   // A finishing instruction may hand over directly to the next one.
   assign accept = start && (state == IDLE || state == DONE || state == ERR);

   always_comb begin
      next_state = IDLE;
      case (state)
         IDLE, DONE, ERR: begin
            if (start) next_state = (decode_op(instructie) != 6'b0) ? RD_A : ERR;
            else       next_state = IDLE;
         end
         RD_A:    next_state = instr_q[5] ? CAP_A : RD_B;
         RD_B:    next_state = CAP_B;
         CAP_B:   next_state = EXEC;
         CAP_A:   next_state = EXEC;
         EXEC:    next_state = WB;
         WB:      next_state = DONE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         instr_q        <= '0;
         a_q            <= '0;
         b_q            <= '0;
         buf_a          <= '0;
         buf_b          <= '0;
         res            <= '0;
         reg_address    <= '0;
         reg_value_in   <= '0;
         outputArgument <= '0;
         retired        <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            instr_q <= instructie;
            a_q     <= argument1[ADDR_WIDTH-1:0];
            b_q     <= argument2;
         end
         // Address is registered so it is stable for the whole strobe cycle.
         if (next_state == RD_A)      reg_address <= argument1[ADDR_WIDTH-1:0];
         else if (next_state == RD_B) reg_address <= b_q[ADDR_WIDTH-1:0];
         else if (next_state == WB)   reg_address <= a_q;
         case (state)
            RD_B:  buf_a <= reg_value_out;
            CAP_B: buf_b <= reg_value_out;
            CAP_A: begin
               buf_a <= reg_value_out;
               buf_b <= b_q[DATA_WIDTH-1:0];
            end
            EXEC: begin
               res          <= alu_result;
               reg_value_in <= alu_result;
            end
            WB: begin
               outputArgument <= res;
               retired        <= retired + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign busy             = (state != IDLE);
   assign done             = (state == DONE) || (state == ERR);
   assign illegal          = (state == ERR);
   assign reg_chip_enable  = (state == RD_A) || (state == RD_B) || (state == WB);
   assign reg_write_enable = (state == WB);
   assign alu_a            = buf_a;
   assign alu_b            = buf_b;
   assign alu_opcode       = (state == EXEC) ? decode_op(instr_q) : 6'b000000;

endmodule

// File: tb/tb_instructie_sequencer.sv
// Directed bench for instructie_sequencer with a behavioural register file and ALU.
module tb_instructie_sequencer;
   logic        clock, reset_n, start;
   logic [7:0]  instructie;
   logic [15:0] argument1, argument2;
   logic        busy, done, illegal;
   logic [15:0] outputArgument;
   logic        reg_chip_enable, reg_write_enable;
   logic [3:0]  reg_address;
   logic [15:0] reg_value_in, reg_value_out;
   logic [15:0] alu_a, alu_b;
   logic [5:0]  alu_opcode;
   logic [15:0] alu_result;
   logic [15:0] retired;

   int total = 0;
   int bad   = 0;
   int ce_cnt = 0;
   int ce_base;

   logic [15:0] rf [16];
   logic [15:0] rf_q = 16'h0;
   logic        pre_we = 1'b0;
   logic [3:0]  pre_addr = 4'h0;
   logic [15:0] pre_dat = 16'h0;

   instructie_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .instructie(instructie),
      .argument1(argument1), .argument2(argument2), .busy(busy), .done(done),
      .illegal(illegal), .outputArgument(outputArgument),
      .reg_chip_enable(reg_chip_enable), .reg_write_enable(reg_write_enable),
      .reg_address(reg_address), .reg_value_in(reg_value_in),
      .reg_value_out(reg_value_out), .alu_a(alu_a), .alu_b(alu_b),
      .alu_opcode(alu_opcode), .alu_result(alu_result), .retired(retired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Register file: synchronous read, data valid the cycle after the strobe.
   always @(posedge clock) begin
      if (pre_we) rf[pre_addr] <= pre_dat;
      else if (reg_chip_enable) begin
         if (reg_write_enable) rf[reg_address] <= reg_value_in;
         else                  rf_q <= rf[reg_address];
      end
      if (reg_chip_enable) ce_cnt <= ce_cnt + 1;
   end
   assign reg_value_out = rf_q;

   always_comb begin
      alu_result = 16'h0;
      case (alu_opcode)
         6'b001000: alu_result = alu_a + alu_b;
         6'b010000: alu_result = alu_a - alu_b;
         6'b100000: alu_result = alu_a ^ alu_b;
         6'b000010: alu_result = alu_a | alu_b;
         6'b000100: alu_result = alu_a & alu_b;
         6'b000001: alu_result = ~alu_a;
         default:   alu_result = 16'h0;
      endcase
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [3:0] a, input logic [15:0] d);
      pre_we = 1'b1; pre_addr = a; pre_dat = d;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic issue(input logic [7:0] ins, input logic [15:0] a1, input logic [15:0] a2);
      instructie = ins; argument1 = a1; argument2 = a2; start = 1'b1;
      ce_base = ce_cnt;
      tick();
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; instructie = 8'h0; argument1 = 16'h0; argument2 = 16'h0;
      for (int i = 0; i < 16; i++) begin
         rf[i] = 16'h0;
      end
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_outarg", outputArgument, 0);
      chk("rst_ce_we", {reg_chip_enable, reg_write_enable}, 0);
      chk("rst_addr_val", {reg_address, reg_value_in}, 0);
      chk("rst_alu", {alu_a, alu_b}, 0);
      chk("rst_opcode", alu_opcode, 0);
      chk("rst_retired", retired, 0);
      reset_n = 1'b1;
      tick();
      preload(4'd1, 16'h0005); preload(4'd2, 16'h0003); preload(4'd4, 16'h0002);
      preload(4'd3, 16'h00FF); preload(4'd5, 16'h0F0F); preload(4'd0, 16'h1234);
      preload(4'd7, 16'hAAAA); preload(4'd6, 16'h0000);

      // Reg-reg ADD R1 = R1 + R2
      issue(8'h01, 16'd1, 16'd2);
      start = 1'b0;
      chk("add_c1_strobe", {busy, reg_chip_enable, reg_write_enable, reg_address}, {3'b110, 4'd1});
      tick();
      chk("add_c2_strobe", {reg_chip_enable, reg_write_enable, reg_address}, {2'b10, 4'd2});
      tick();
      chk("add_c3_ce", reg_chip_enable, 0);
      tick();
      chk("add_c4_opcode", alu_opcode, 6'b001000);
      chk("add_c4_ops", {alu_a, alu_b}, {16'h0005, 16'h0003});
      tick();
      chk("add_c5_wb", {reg_chip_enable, reg_write_enable, reg_address, reg_value_in}, {2'b11, 4'd1, 16'h0008});
      chk("add_c5_nodone", done, 0);
      tick();
      chk("add_c6_done", {done, illegal}, 2'b10);
      chk("add_outarg", outputArgument, 16'h0008);
      chk("add_retired", retired, 16'd1);
      chk("add_r1", rf[1], 16'h0008);
      chk("add_ce_count", ce_cnt - ce_base, 3);
      tick();
      chk("add_idle", {busy, done}, 2'b00);

      // Immediate SUB wrap: R4 = 2 - 5
      issue(8'h22, 16'd4, 16'h0005);
      start = 1'b0;
      chk("sub_c1_strobe", {reg_chip_enable, reg_write_enable, reg_address}, {2'b10, 4'd4});
      tick();
      chk("sub_c2_noread", reg_chip_enable, 0);
      tick();
      chk("sub_c3_exec", {alu_opcode, alu_a, alu_b}, {6'b010000, 16'h0002, 16'h0005});
      tick();
      chk("sub_c4_wb", {reg_write_enable, reg_value_in}, {1'b1, 16'hFFFD});
      tick();
      chk("sub_c5_done", done, 1);
      chk("sub_r4", rf[4], 16'hFFFD);
      chk("sub_outarg_ret", {outputArgument, retired}, {16'hFFFD, 16'd2});
      chk("sub_ce_count", ce_cnt - ce_base, 2);
      tick();

      // Illegal opcodes: unsupported operation, then reserved top bits
      issue(8'h07, 16'd1, 16'd2);
      start = 1'b0;
      chk("ill07_flags", {busy, done, illegal, reg_chip_enable}, 4'b1110);
      tick();
      chk("ill07_after", {busy, done, illegal}, 3'b000);
      issue(8'h41, 16'd1, 16'd2);
      start = 1'b0;
      chk("ill41_flags", {done, illegal, reg_chip_enable}, 3'b110);
      tick();
      chk("ill_no_access", ce_cnt - ce_base, 0);
      chk("ill_outarg_ret", {outputArgument, retired}, {16'hFFFD, 16'd2});

      // Back-to-back with start held high: R3 ^= R5, then R6 = R6 + 0x10
      issue(8'h03, 16'd3, 16'd5);
      chk("b2b_c1_addr", reg_address, 4'd3);
      tick();
      chk("b2b_c2_addr", {reg_chip_enable, reg_address}, {1'b1, 4'd5});
      tick(); tick(); tick();
      chk("b2b_c5_nodone", done, 0);
      tick();
      chk("b2b_c6_done", done, 1);
      chk("b2b_r3", rf[3], 16'h0FF0);
      chk("b2b_ret1", retired, 16'd3);
      instructie = 8'h21; argument1 = 16'd6; argument2 = 16'h0010;
      tick();
      start = 1'b0;
      chk("b2b_second_accept", {busy, done, reg_chip_enable, reg_address}, {3'b101, 4'd6});
      tick(); tick(); tick(); tick();
      chk("b2b_second_done", done, 1);
      chk("b2b_r6", rf[6], 16'h0010);
      chk("b2b_ret2", retired, 16'd4);
      tick();

      // NOT with retired counter wrap
      force dut.retired = 16'hFFFF;
      #1;
      release dut.retired;
      chk("wrap_preset", retired, 16'hFFFF);
      issue(8'h06, 16'd0, 16'd7);
      start = 1'b0;
      tick();
      chk("not_b_read", {reg_chip_enable, reg_address}, {1'b1, 4'd7});
      tick(); tick();
      chk("not_exec", {alu_opcode, alu_a}, {6'b000001, 16'h1234});
      tick(); tick();
      chk("not_done", done, 1);
      chk("not_r0", rf[0], 16'hEDCB);
      chk("not_wrap", {outputArgument, retired}, {16'hEDCB, 16'h0000});
      tick();

      // Asynchronous reset in the middle of write-back
      issue(8'h01, 16'd1, 16'd2);
      start = 1'b0;
      tick(); tick(); tick(); tick();
      chk("rstwb_we_before", reg_write_enable, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rstwb_strobes", {reg_chip_enable, reg_write_enable}, 2'b00);
      chk("rstwb_busy_done", {busy, done}, 2'b00);
      tick();
      chk("rstwb_r1_kept", rf[1], 16'h0008);
      reset_n = 1'b1;
      tick(); tick();
      chk("rstwb_no_done", {busy, done, outputArgument}, {2'b00, 16'h0000});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
